exmem_ctrl: RTL
===============

Name: exmem_ctrl

Overview:
- Wishbone classic slave modelling the external memory in the 0x38xx_xxxx window.
- Sits directly downstream of the CPU/DMA arbiter and consumes the single arbitrated request stream from the CPU and the fir/qs/mm DMA engines.
- Adds a programmable access latency, emulating off-chip SDRAM, so DMA throughput is measured realistically.
- Has an optional sequential-read prefetch buffer.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W 32-bit words.
- DELAY, 10, wait cycles per miss access; legal range 1..255.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle valid
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address; bits [ADDR_W+1:2] used, others ignored
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge, one-cycle pulse
- wbs_dat_o  out  32  read data
- busy_o  out  1  high while an access is in progress
- pf_hit_o  out  1  one-cycle pulse on a prefetch hit; tied 0 when the feature is absent

Behaviour:
- Clocking/reset: one clock, wb_clk_i; reset wb_rst_i is asynchronous, active-high.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, busy_o=0, pf_hit_o=0, FSM=IDLE, counter=0, prefetch valid=0. Memory contents are not reset.
- FSM states:
  - IDLE: request = stb&cyc. On request, latch adr/we/sel/dat, load counter with DELAY-1 and go to WAIT. busy_o=1 from the next cycle.
  - WAIT: decrement the counter; at 0 go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. busy_o=0 in the following IDLE.
- Latency: ack is asserted DELAY+1 cycles after the cycle in which stb is first sampled high in IDLE.
- Reads: wbs_dat_o = mem[word] during the ACK cycle; 0 in all other cycles.
- Writes: byte lanes selected by sel are written on the clock edge that ends ACK.
- sel=0 write: acked, memory unchanged.
- Back-to-back requests: a request held high in the cycle after ACK is treated as a new request. There is no double ack because ACK always passes through IDLE.
- Abort: cyc dropping in WAIT returns the FSM to IDLE next cycle with no ack and no write. stb dropping with cyc high is ignored; the access completes.
- Address: word index = wbs_adr_i[ADDR_W+1:2]. Out-of-range upper bits alias.
- Reset mid-access: the access is discarded, no ack, and no write occurs.

Optional Feature:
- Macro: EXMEM_PREFETCH_EN.
- With macro, prefetch fill: on every read ACK to word A, the buffer loads mem[(A+1) mod 2**ADDR_W], tag=A+1, valid=1. Wrap-around at the top word gives tag 0.
- With macro, hit path: a later read whose word equals the tag with valid=1 skips WAIT. IDLE goes to ACK, giving latency 1 cycle. Data comes from the buffer and pf_hit_o pulses in the ACK cycle.
- With macro, invalidation: any write sets valid=0. If a write and a refill would coincide, invalidate wins.
- With macro, abort: an aborted access leaves the buffer unchanged.
- Without macro: every access takes DELAY+1 cycles and pf_hit_o=0.

Decomposition:
- Package exmem_pkg holds:
  - FSM state encoding (IDLE, WAIT, ACK);
  - counter width constant (8 bits);
  - base-window constant 8'h38.
- Natural sub-module: exmem_ram, a single-port 32-bit byte-writable array with ADDR_W address bits and a combinational read. The controller FSM, counter and prefetch logic stay in exmem_ctrl.

Test Plan:
- Write then read, DELAY=10: write 0x3800_0010 data 0xDEADBEEF sel=F, then read 0x3800_0010. Each ack is 11 cycles after stb; read returns 0xDEADBEEF; busy_o is high throughout.
- Byte lanes: write 0x11223344 sel=F, then 0xAABBCCDD sel=0101, then read. Returns 0x11BB33DD.
- Abort: read request, cyc dropped at cycle 4 of WAIT. No ack; FSM back in IDLE next cycle; an immediate new read acks at the full DELAY+1.
- Reset mid-WAIT: assert rst during a write to word 5. Ack, busy_o and dat_o go to 0 at once; a later read of word 5 returns the old value.
- Prefetch (macro on): read words 3 then 4. Word 4 acks 1 cycle after stb with pf_hit_o=1 and correct data. Then write word 5 and read word 5: full latency, pf_hit_o=0.
- Prefetch wrap (macro on), ADDR_W=10: read word 1023 then word 0. Word 0 hits with latency 1. With the macro off the same sequence gives 11-cycle latency and pf_hit_o=0.

Source files
------------

// File: rtl/exmem_pkg.sv
// exmem_pkg: shared types and constants for the external-memory model.
//   state_e    - controller FSM encoding (idle, wait, ack)
//   CNT_W      - width of the latency down-counter
//   BASE_WIN   - top address byte of the external-memory window (0x38xx_xxxx)
//   delay_load - counter preload for a given miss latency
package exmem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

    localparam int unsigned CNT_W    = 8;
    localparam logic [7:0]  BASE_WIN = 8'h38;

    // The counter runs DELAY-1 .. 0 inside WAIT, giving DELAY wait cycles.
    function automatic logic [CNT_W-1:0] delay_load(input int unsigned delay);
        return CNT_W'(delay - 1);
    endfunction

endpackage

// File: rtl/exmem_if.sv
// exmem_if: Wishbone classic bus between the arbiter (master) and exmem_ctrl (slave).
//   wbs_stb_i, wbs_cyc_i, wbs_we_i  - strobe, cycle valid, write enable
//   wbs_sel_i [3:0]                 - byte lanes
//   wbs_adr_i [31:0]                - byte address
//   wbs_dat_i [31:0]                - write data
//   wbs_ack_o                       - one-cycle acknowledge
//   wbs_dat_o [31:0]                - read data
interface exmem_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/exmem_ram.sv
// exmem_ram: single-port 32-bit byte-writable memory, 2**ADDR_W words.
//   clk        - clock
//   we         - write enable (applies lanes in sel)
//   sel [3:0]  - byte lanes
//   addr       - word address
//   wdata      - write data
//   rdata      - combinational read of addr
// Contents are not reset.
module exmem_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/exmem_ctrl.sv
// exmem_ctrl: Wishbone classic slave modelling slow external memory (0x38xx_xxxx window).
//   wb_clk_i  - clock
//   wb_rst_i  - asynchronous active-high reset
//   bus       - exmem_if slave modport (stb/cyc/we/sel/adr/dat in, ack/dat out)
//   busy_o    - high while an access is in progress
//   pf_hit_o  - one-cycle pulse when a read is served from the prefetch buffer
// Each miss takes DELAY wait cycles; ack arrives DELAY+1 cycles after the request.
// Optional feature macro EXMEM_PREFETCH_EN: one-word sequential-read prefetch buffer.
// Without it pf_hit_o is tied low.
module exmem_ctrl
    import exmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DELAY  = 10
) (
    input  logic    wb_clk_i,
    input  logic    wb_rst_i,
    exmem_if.slave  bus,
    output logic    busy_o,
    output logic    pf_hit_o
);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] adr_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       wdat_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              busy_q;
    logic              hit_q;

    logic              req;
    logic [ADDR_W-1:0] req_word;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic              pf_hit_req;
    logic [31:0]       pf_data;
    logic              unused_adr;

    assign req      = bus.wbs_stb_i & bus.wbs_cyc_i;
    assign req_word = bus.wbs_adr_i[ADDR_W+1:2];
    // Upper address bits alias; byte offset is irrelevant for word accesses.
    assign unused_adr = ^{bus.wbs_adr_i[31:ADDR_W+2], bus.wbs_adr_i[1:0]};

    // The write lands on the edge that ends ACK, so a reset or abort never writes.
    assign ram_we = (state_q == StAck) & we_q;

`ifdef EXMEM_PREFETCH_EN
    logic              pf_valid_q;
    logic [ADDR_W-1:0] pf_tag_q;
    logic [31:0]       pf_data_q;

    // Read data was captured on entry to ACK, so the single port is free during a
    // read ACK to fetch the next sequential word for the buffer. Wraps at the top.
    assign ram_addr   = (state_q == StAck && !we_q) ? adr_q + ADDR_W'(1) : adr_q;
    assign pf_hit_req = req & ~bus.wbs_we_i & pf_valid_q & (req_word == pf_tag_q);
    assign pf_data    = pf_data_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
        end else if (state_q == StAck) begin
            // Writes invalidate; only completed reads refill.
            if (we_q) begin
                pf_valid_q <= 1'b0;
            end else begin
                pf_valid_q <= 1'b1;
                pf_tag_q   <= ram_addr;
                pf_data_q  <= ram_rdata;
            end
        end
    end
`else
    assign ram_addr   = adr_q;
    assign pf_hit_req = 1'b0;
    assign pf_data    = 32'h0;
`endif

    exmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .sel   (sel_q),
        .addr  (ram_addr),
        .wdata (wdat_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdat_q  <= 32'h0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    dat_q <= 32'h0;
                    hit_q <= 1'b0;
                    if (req) begin
                        adr_q  <= req_word;
                        we_q   <= bus.wbs_we_i;
                        sel_q  <= bus.wbs_sel_i;
                        wdat_q <= bus.wbs_dat_i;
                        busy_q <= 1'b1;
                        if (pf_hit_req) begin
                            state_q <= StAck;
                            ack_q   <= 1'b1;
                            dat_q   <= pf_data;
                            hit_q   <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= delay_load(DELAY);
                        end
                    end
                end
                StWait: begin
                    // Only cyc aborts; a dropped stb alone lets the access finish.
                    if (!bus.wbs_cyc_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                        dat_q   <= we_q ? 32'h0 : ram_rdata;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StAck: begin
                    // Always return through IDLE so a held request cannot double-ack.
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    dat_q   <= 32'h0;
                    hit_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;
    assign busy_o        = busy_q;
    assign pf_hit_o      = hit_q;

endmodule
